// File: rtl/mmio_port_bank.sv
// mmio_port_bank: bank of NUM_PORTS memory-mapped I/O ports on the CPU bus.
// Each port has four byte registers at BASE_ADDR+4p: DATA, DIR, IEN and ISR.
// Pin inputs are synchronised. A rising edge on an input bit sets that bit's
// ISR flag, and irq is the OR of all enabled ISR flags.
module mmio_port_bank #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned PORT_W      = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h8400,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bus_stb,
    input  logic [15:0]                   bus_addr,
    input  logic                          bus_we,
    input  logic [7:0]                    bus_wdata,
    output logic                          bus_hit,
    output logic [7:0]                    bus_rdata,
    input  logic [NUM_PORTS*PORT_W-1:0]   pins_in,
    output logic [NUM_PORTS*PORT_W-1:0]   pins_out,
    output logic [NUM_PORTS*PORT_W-1:0]   pins_oe,
    output logic                          irq
);

    localparam int unsigned TOT_W  = NUM_PORTS * PORT_W;
    localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [16:0] WIN_HI = WIN_LO + 17'(4 * NUM_PORTS);

    logic [15:0]      offset;
    logic [13:0]      port_sel;
    logic [1:0]       reg_sel;
    logic             wr_hit;
    logic             rd_hit;

    logic [TOT_W-1:0] out_q, out_d;
    logic [TOT_W-1:0] dir_q, dir_d;
    logic [TOT_W-1:0] ien_q, ien_d;
    logic [TOT_W-1:0] isr_q, isr_d;
    logic [TOT_W-1:0] w1c_mask;
    logic [TOT_W-1:0] sync_q [SYNC_STAGES];
    logic [TOT_W-1:0] sync_d [SYNC_STAGES];
    logic [TOT_W-1:0] prev_q, prev_d;
    logic [TOT_W-1:0] pin_sync;
    logic [TOT_W-1:0] rise;
    logic [7:0]       rdata_q, rdata_d;
    logic             irq_q, irq_d;

    // The window bounds are compared in 17 bits, so a window that ends at 0xFFFF cannot wrap.
    assign bus_hit  = ({1'b0, bus_addr} >= WIN_LO) && ({1'b0, bus_addr} < WIN_HI);
    assign offset   = bus_addr - BASE_ADDR;
    assign port_sel = offset[15:2];
    assign reg_sel  = offset[1:0];
    assign wr_hit   = bus_stb & bus_we & bus_hit;
    assign rd_hit   = bus_stb & ~bus_we & bus_hit;

    // The edge detector always runs, whatever DIR is. Only setting ISR depends on DIR.
    assign pin_sync = sync_q[SYNC_STAGES-1];
    assign rise     = pin_sync & ~prev_q;

    assign pins_out  = out_q;
    assign pins_oe   = dir_q;
    assign bus_rdata = rdata_q;
    assign irq       = irq_q;

    // Synchroniser chain and the edge-detector history flop.
    always_comb begin
        sync_d[0] = pins_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = pin_sync;
    end

    // Register writes, read-data capture, ISR set and clear, and IRQ reduction.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ien_d    = ien_q;
        w1c_mask = '0;
        rdata_d  = rdata_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_sel == 14'(p)) begin
                if (wr_hit) begin
                    case (reg_sel)
                        2'd0:    out_d[p*PORT_W +: PORT_W]    = bus_wdata[PORT_W-1:0];
                        2'd1:    dir_d[p*PORT_W +: PORT_W]    = bus_wdata[PORT_W-1:0];
                        2'd2:    ien_d[p*PORT_W +: PORT_W]    = bus_wdata[PORT_W-1:0];
                        default: w1c_mask[p*PORT_W +: PORT_W] = bus_wdata[PORT_W-1:0];
                    endcase
                end
                if (rd_hit) begin
                    case (reg_sel)
                        2'd0:    rdata_d = 8'((dir_q[p*PORT_W +: PORT_W] & out_q[p*PORT_W +: PORT_W]) |
                                              (~dir_q[p*PORT_W +: PORT_W] & pin_sync[p*PORT_W +: PORT_W]));
                        2'd1:    rdata_d = 8'(dir_q[p*PORT_W +: PORT_W]);
                        2'd2:    rdata_d = 8'(ien_q[p*PORT_W +: PORT_W]);
                        default: rdata_d = 8'(isr_q[p*PORT_W +: PORT_W]);
                    endcase
                end
            end
        end
        // If an edge and a write-1-to-clear hit the same bit in one cycle, the set wins.
        isr_d = (isr_q & ~w1c_mask) | (rise & ~dir_q);
        irq_d = |(isr_q & ien_q);
    end

    // Synchroniser and edge-detector state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q <= prev_d;
        end
    end

    // Architectural registers, read-data holding register and the IRQ output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            isr_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            isr_q   <= isr_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_mmio_port_bank.sv
// Testbench for mmio_port_bank. A reference model computes expected register
// state and read data. A monitor checks the DUT against it on every falling
// edge. Directed scenarios come first, then randomized bus and pin traffic.
module tb_mmio_port_bank;

    localparam int          NP   = 2;
    localparam int          PW   = 8;
    localparam int          S    = 2;
    localparam logic [15:0] BASE = 16'h8400;

    logic        clk;
    logic        reset;
    logic        bus_stb;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic        bus_hit;
    logic [7:0]  bus_rdata;
    logic [15:0] pins_in;
    logic [15:0] pins_out;
    logic [15:0] pins_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_port_bank #(
        .NUM_PORTS(NP), .PORT_W(PW), .BASE_ADDR(BASE), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .bus_stb(bus_stb), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_hit(bus_hit),
        .bus_rdata(bus_rdata), .pins_in(pins_in), .pins_out(pins_out),
        .pins_oe(pins_oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_window(input logic [15:0] a);
        return (a >= BASE) && (a < BASE + 16'(4 * NP));
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  m_out [NP];
    logic [7:0]  m_dir [NP];
    logic [7:0]  m_ien [NP];
    logic [7:0]  m_isr [NP];
    logic [15:0] hist  [S+1];   // hist[k] = pins_in sampled k+1 edges ago
    logic [7:0]  m_rdata;
    logic        m_irq;
    logic [7:0]  exp_q [$];

    logic [15:0] sv_v, rise_v;
    logic [7:0]  rd_v, w1c_v;
    logic        irq_n;
    int          pp, rr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                m_out[i] = '0; m_dir[i] = '0; m_ien[i] = '0; m_isr[i] = '0;
            end
            for (int i = 0; i <= S; i++) hist[i] = '0;
            m_rdata = '0;
            m_irq   = 1'b0;
            exp_q.delete();
        end else begin
            sv_v   = hist[S-1];
            rise_v = sv_v & ~hist[S];
            irq_n  = 1'b0;
            for (int i = 0; i < NP; i++) irq_n = irq_n | (|(m_isr[i] & m_ien[i]));
            pp = 0; rr = 0; w1c_v = '0;
            if (bus_stb && in_window(bus_addr)) begin
                pp = int'(bus_addr - BASE) / 4;
                rr = int'(bus_addr - BASE) % 4;
                if (!bus_we) begin
                    case (rr)
                        0: rd_v = (m_dir[pp] & m_out[pp]) | (~m_dir[pp] & sv_v[pp*8 +: 8]);
                        1: rd_v = m_dir[pp];
                        2: rd_v = m_ien[pp];
                        default: rd_v = m_isr[pp];
                    endcase
                    m_rdata = rd_v;
                    exp_q.push_back(rd_v);
                end else if (rr == 3) begin
                    w1c_v = bus_wdata;
                end
            end
            for (int i = 0; i < NP; i++) begin
                m_isr[i] = (m_isr[i] & ~((i == pp) ? w1c_v : 8'h00)) |
                           (rise_v[i*8 +: 8] & ~m_dir[i]);
            end
            if (bus_stb && bus_we && in_window(bus_addr)) begin
                case (rr)
                    0: m_out[pp] = bus_wdata;
                    1: m_dir[pp] = bus_wdata;
                    2: m_ien[pp] = bus_wdata;
                    default: ;
                endcase
            end
            m_irq = irq_n;
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pins_in;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("pins_out", pins_out, {m_out[1], m_out[0]});
            check("pins_oe", pins_oe, {m_dir[1], m_dir[0]});
            check("irq", {15'd0, irq}, {15'd0, m_irq});
            check("rdata_hold", {8'd0, bus_rdata}, {8'd0, m_rdata});
            if (exp_q.size() > 0) check("read_data", {8'd0, bus_rdata}, {8'd0, exp_q.pop_front()});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic stb, input logic we, input logic [15:0] a, input logic [7:0] d);
        bus_stb = stb; bus_we = we; bus_addr = a; bus_wdata = d;
        #1;
        check("bus_hit", {15'd0, bus_hit}, {15'd0, in_window(a)});
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d);
        @(negedge clk);
        drive(1'b0, 1'b0, a, 8'h00);
    endtask

    task automatic bus_read(input logic [15:0] a);
        drive(1'b1, 1'b0, a, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, a, 8'h00);
    endtask

    initial begin
        reset = 1'b1; bus_stb = 1'b0; bus_addr = '0; bus_we = 1'b0;
        bus_wdata = '0; pins_in = '0;
        @(posedge clk); #1;
        check("rst_pins_out", pins_out, 16'h0000);
        check("rst_pins_oe", pins_oe, 16'h0000);
        check("rst_irq", {15'd0, irq}, 16'h0000);
        check("rst_rdata", {8'd0, bus_rdata}, 16'h0000);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // 1: DIR then DATA on port 0
        bus_write(16'h8401, 8'hA5);
        bus_write(16'h8400, 8'h3C);
        check("t1_out", pins_out, 16'h003C);
        check("t1_oe", pins_oe, 16'h00A5);

        // 2: mixed-direction read-back
        bus_write(16'h8401, 8'h0F);
        bus_write(16'h8400, 8'h0A);
        pins_in[7:0] = 8'h50;
        repeat (4) @(negedge clk);
        bus_read(16'h8400);
        check("t2_read", {8'd0, bus_rdata}, 16'h005A);

        // 3: rising edge on pin 8 -> ISR and irq timing, then W1C
        bus_write(16'h8406, 8'h01);
        pins_in[8] = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t3_irq_early", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        check("t3_irq_set", {15'd0, irq}, 16'h0001);
        bus_read(16'h8407);
        check("t3_isr", {8'd0, bus_rdata}, 16'h0001);
        bus_write(16'h8407, 8'h01);
        @(negedge clk);
        check("t3_irq_clr", {15'd0, irq}, 16'h0000);

        // 4: edge arriving in the same cycle as W1C -> set wins
        pins_in[8] = 1'b0;
        repeat (4) @(negedge clk);
        pins_in[8] = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_irq_pre", {15'd0, irq}, 16'h0001);
        pins_in[8] = 1'b0;
        repeat (4) @(negedge clk);
        pins_in[8] = 1'b1;
        @(negedge clk); @(negedge clk);
        bus_write(16'h8407, 8'h01);
        @(negedge clk);
        check("t4_irq_stay", {15'd0, irq}, 16'h0001);
        bus_read(16'h8407);
        check("t4_isr_stay", {8'd0, bus_rdata}, 16'h0001);

        // 5: access just past the window has no effect
        bus_write(16'h8408, 8'hFF);
        bus_read(16'h8408);
        check("t5_rdata", {8'd0, bus_rdata}, 16'h0001);
        check("t5_oe", pins_oe, 16'h000F);
        check("t5_out", pins_out, 16'h000A);

        // 6: reset in the middle of a write while irq is high
        drive(1'b1, 1'b1, 16'h8401, 8'hFF);
        #2 reset = 1'b1;
        #1;
        check("t6_out", pins_out, 16'h0000);
        check("t6_oe", pins_oe, 16'h0000);
        check("t6_irq", {15'd0, irq}, 16'h0000);
        check("t6_rdata", {8'd0, bus_rdata}, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        pins_in = '0;
        reset = 1'b0;
        @(negedge clk);
        check("t6_lost", pins_oe, 16'h0000);

        // randomized traffic around and inside the window
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) pins_in = 16'($urandom);
            if ($urandom_range(0, 2) != 0)
                drive(1'b1, 1'($urandom), 16'h83FC + 16'($urandom_range(0, 15)), 8'($urandom));
            else
                drive(1'b0, 1'b0, 16'h83FC + 16'($urandom_range(0, 15)), 8'h00);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        repeat (2) @(negedge clk);
        check("sb_drained", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
